// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared constants and helpers for the mux4 scan sequencer.
//               NCH    - number of mux channels
//               SEL_W  - select width
//               AN_OFF - all digit enables inactive (active-low)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int          NCH    = 4;
    localparam int          SEL_W  = 2;
    localparam logic [3:0]  AN_OFF = 4'b1111;

    typedef enum logic {
        MODE_AUTO   = 1'b0,
        MODE_MANUAL = 1'b1
    } scan_mode_e;

    // Active-low one-hot digit enable for a channel.
    function automatic logic [NCH-1:0] onehot_n(input logic [SEL_W-1:0] sel);
        onehot_n = ~(4'b0001 << sel);
    endfunction

    // Round-robin search: first enabled channel in order sel+1 .. sel+4.
    // The sel+4 candidate wraps to sel itself, so a lone enabled channel
    // re-selects itself; an empty mask returns sel unchanged.
    function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] sel,
                                                      input logic [NCH-1:0]   mask);
        logic [SEL_W-1:0] cand;
        logic             found;
        next_enabled = sel;
        found        = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            cand = sel + SEL_W'(i);
            if (!found && mask[cand]) begin
                next_enabled = cand;
                found        = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler counting 0..DIV-1 with a registered
//               slot-end pulse. Reusable for other display timing.
// Ports       : clk   - system clock
//               rst   - synchronous active-high reset
//               en    - count enable; low holds count and forces tick low
//               clr   - restart slot (count -> 0, no tick this edge)
//               count - current prescaler value
//               tick  - high for the cycle after count == DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter  int DIV = 100000,
    localparam int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (en) begin
            if (clr) begin
                r_count <= '0;
                r_tick  <= 1'b0;
            end else if (r_count == c_LAST) begin
                r_count <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;

endmodule
`default_nettype wire

// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux4_scan_ctrl
// Description : Timed round-robin sequencer for a 4-to-1 mux. Drives the mux
//               selects and active-low digit enables, and samples the mux
//               output back SETTLE cycles into each slot.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               en                - run enable (low freezes all state)
//               manual, man_sel   - manual channel override
//               ch_mask           - auto-scan channel enables
//               f_in              - mux output fed back
//               s0, s1, an        - mux selects, active-low one-hot enable
//               tick              - slot-end pulse
//               cap_valid/ch/data - capture pulse, channel and sample
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DIV    = 100000,
    parameter int SETTLE = 2,
    parameter int W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             manual,
    input  logic [1:0]       man_sel,
    input  logic [3:0]       ch_mask,
    input  logic [W-1:0]     f_in,
    output logic             s0,
    output logic             s1,
    output logic [3:0]       an,
    output logic             tick,
    output logic             cap_valid,
    output logic [1:0]       cap_ch,
    output logic [W-1:0]     cap_data
);

    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] c_SETTLE = CW'(SETTLE);
    localparam logic [CW-1:0] c_LAST   = CW'(DIV - 1);

    logic [SEL_W-1:0] r_sel;
    logic             r_cap_valid;
    logic [SEL_W-1:0] r_cap_ch;
    logic [W-1:0]     r_cap_data;

    logic [CW-1:0]    w_count;
    logic             w_tick;
    scan_mode_e       w_mode;
    logic             w_reload;
    logic             w_wrap;
    logic             w_lit;
    logic [3:0]       w_an;
    logic [SEL_W-1:0] w_sel_nxt;

    assign w_mode   = manual ? MODE_MANUAL : MODE_AUTO;
    // A manual channel change restarts the slot; it also masks a coincident
    // wrap because the prescaler clear suppresses the tick.
    assign w_reload = (w_mode == MODE_MANUAL) && (man_sel != r_sel);
    assign w_wrap   = (w_count == c_LAST);

    // Blanking follows the mask combinationally so a channel that is masked
    // out goes dark immediately rather than at the next slot boundary.
    assign w_lit = (w_mode == MODE_MANUAL) || ch_mask[r_sel];
    assign w_an  = w_lit ? onehot_n(r_sel) : AN_OFF;

    tick_gen #(
        .DIV   (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (w_reload),
        .count (w_count),
        .tick  (w_tick)
    );

    always_comb begin
        w_sel_nxt = r_sel;
        if (w_reload) begin
            w_sel_nxt = man_sel;
        end else if ((w_mode == MODE_AUTO) && w_wrap) begin
            w_sel_nxt = next_enabled(r_sel, ch_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= '0;
            r_cap_valid <= 1'b0;
            r_cap_ch    <= '0;
            r_cap_data  <= '0;
        end else if (en) begin
            r_sel <= w_sel_nxt;
            // One sample per slot, taken with the select that was driving the
            // mux during the settle interval.
            if ((w_count == c_SETTLE) && (w_an != AN_OFF)) begin
                r_cap_valid <= 1'b1;
                r_cap_ch    <= r_sel;
                r_cap_data  <= f_in;
            end else begin
                r_cap_valid <= 1'b0;
            end
        end else begin
            r_cap_valid <= 1'b0;
        end
    end

    assign s0        = r_sel[0];
    assign s1        = r_sel[1];
    assign an        = w_an;
    assign tick      = w_tick;
    assign cap_valid = r_cap_valid;
    assign cap_ch    = r_cap_ch;
    assign cap_data  = r_cap_data;

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_scan_ctrl
// Description : Self-checking bench for mux4_scan_ctrl with a behavioural
//               slot model, a mux model closing the f_in loop, directed
//               scenarios and a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_ctrl;

    localparam int DIV    = 4;
    localparam int SETTLE = 1;
    localparam int W      = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         manual;
    logic [1:0]   man_sel;
    logic [3:0]   ch_mask;
    logic [W-1:0] f_in;
    logic         s0, s1;
    logic [3:0]   an;
    logic         tick;
    logic         cap_valid;
    logic [1:0]   cap_ch;
    logic [W-1:0] cap_data;

    logic [W-1:0] wv [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux4_scan_ctrl #(
        .DIV       (DIV),
        .SETTLE    (SETTLE),
        .W         (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .manual    (manual),
        .man_sel   (man_sel),
        .ch_mask   (ch_mask),
        .f_in      (f_in),
        .s0        (s0),
        .s1        (s1),
        .an        (an),
        .tick      (tick),
        .cap_valid (cap_valid),
        .cap_ch    (cap_ch),
        .cap_data  (cap_data)
    );

    // The mux being scanned.
    always_comb f_in = wv[{s1, s0}];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] an_for(input int ch);
        case (ch)
            0:       an_for = 4'b1110;
            1:       an_for = 4'b1101;
            2:       an_for = 4'b1011;
            default: an_for = 4'b0111;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int m_cnt, m_sel, m_cch, m_cdat;
    bit m_tick, m_cv, m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit lit;
        int k;
        if (rst) begin
            m_cnt = 0; m_sel = 0; m_tick = 0; m_cv = 0; m_cch = 0; m_cdat = 0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            if (en) begin
                lit = manual || ch_mask[m_sel];
                if (m_cnt == SETTLE && lit) begin
                    m_cv = 1; m_cch = m_sel; m_cdat = int'(wv[m_sel]);
                end else begin
                    m_cv = 0;
                end
                if (manual && int'(man_sel) != m_sel) begin
                    m_sel  = int'(man_sel);
                    m_cnt  = 0;
                    m_tick = 0;
                end else begin
                    m_tick = (m_cnt == DIV - 1);
                    m_cnt  = (m_cnt + 1) % DIV;
                    if (!manual && m_tick && ch_mask != 4'b0000) begin
                        k = 1;
                        while (!ch_mask[(m_sel + k) % 4]) k++;
                        m_sel = (m_sel + k) % 4;
                    end
                end
            end else begin
                m_tick = 0;
                m_cv   = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("sel",       {30'd0, s1, s0}, m_sel);
            chk("an",        {28'd0, an}, (manual || ch_mask[m_sel]) ? an_for(m_sel) : 4'b1111);
            chk("tick",      {31'd0, tick}, m_tick);
            chk("cap_valid", {31'd0, cap_valid}, m_cv);
            chk("cap_ch",    {30'd0, cap_ch}, m_cch);
            chk("cap_data",  {29'd0, cap_data}, m_cdat);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cap(input string nm, input int ch, input int d);
        chk({nm, "_v"},  {31'd0, cap_valid}, 1);
        chk({nm, "_ch"}, {30'd0, cap_ch}, ch);
        chk({nm, "_d"},  {29'd0, cap_data}, d);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; manual = 1'b0; man_sel = 2'd0; ch_mask = 4'b1111;
        wv[0] = 3'd1; wv[1] = 3'd2; wv[2] = 3'd3; wv[3] = 3'd4;

        // Reset
        step(2);
        chk("rst_sel", {30'd0, s1, s0}, 0);
        chk("rst_an", {28'd0, an}, 4'b1110);
        chk("rst_tick", {31'd0, tick}, 0);
        chk("rst_cv", {31'd0, cap_valid}, 0);
        rst = 1'b0;

        // Auto scan over all channels
        step(2);  chk_cap("auto_c0", 0, 1);
        step(2);
        chk("auto_sel1", {30'd0, s1, s0}, 1);
        chk("auto_tick1", {31'd0, tick}, 1);
        chk("auto_an1", {28'd0, an}, 4'b1101);
        step(2);  chk_cap("auto_c1", 1, 2);
        step(4);  chk_cap("auto_c2", 2, 3);
        step(4);  chk_cap("auto_c3", 3, 4);
        step(2);
        chk("auto_wrap_sel", {30'd0, s1, s0}, 0);
        chk("auto_wrap_tick", {31'd0, tick}, 1);

        // Reset mid-slot
        step(1);
        rst = 1'b1;
        step(1);
        chk("mrst_sel", {30'd0, s1, s0}, 0);
        chk("mrst_an", {28'd0, an}, 4'b1110);
        chk("mrst_cv", {31'd0, cap_valid}, 0);
        rst = 1'b0;

        // Sparse mask 1010
        ch_mask = 4'b1010;
        #1 chk("mask_blank", {28'd0, an}, 4'b1111);
        step(2);  chk("mask_nocap", {31'd0, cap_valid}, 0);
        step(2);
        chk("mask_sel1", {30'd0, s1, s0}, 1);
        chk("mask_an1", {28'd0, an}, 4'b1101);
        step(2);  chk_cap("mask_c1", 1, 2);
        step(2);
        chk("mask_sel3", {30'd0, s1, s0}, 3);
        chk("mask_an3", {28'd0, an}, 4'b0111);

        // Empty mask
        ch_mask = 4'b0000;
        #1 chk("empty_an", {28'd0, an}, 4'b1111);
        step(2);  chk("empty_nocap", {31'd0, cap_valid}, 0);
        step(2);  chk("empty_hold", {30'd0, s1, s0}, 3);

        // en freeze mid-slot
        ch_mask = 4'b1111;
        step(2);
        en = 1'b0;
        step(5);
        chk("frz_sel", {30'd0, s1, s0}, 3);
        chk("frz_an", {28'd0, an}, 4'b0111);
        chk("frz_tick", {31'd0, tick}, 0);
        chk("frz_cv", {31'd0, cap_valid}, 0);
        en = 1'b1;
        step(1);  chk("frz_rem", {31'd0, tick}, 0);
        step(1);
        chk("frz_wrap_sel", {30'd0, s1, s0}, 0);
        chk("frz_wrap_tick", {31'd0, tick}, 1);

        // Manual reload at prescaler == 2
        step(2);
        manual = 1'b1; man_sel = 2'd2;
        step(1);
        chk("man_sel", {30'd0, s1, s0}, 2);
        chk("man_tick", {31'd0, tick}, 0);
        step(2);  chk_cap("man_c2", 2, 3);
        step(4);  chk_cap("man_c2b", 2, 3);
        chk("man_hold", {30'd0, s1, s0}, 2);

        // Manual reload coincident with the wrap
        manual = 1'b0;
        step(1);
        manual = 1'b1; man_sel = 2'd0;
        step(1);
        chk("sim_sel", {30'd0, s1, s0}, 0);
        chk("sim_tick", {31'd0, tick}, 0);
        manual = 1'b0;

        // Randomized soak
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) manual  = ~manual;
            if ($urandom_range(0, 7)  == 0) man_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) ch_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9)  == 0) wv[$urandom_range(0, 3)] = W'($urandom_range(0, 7));
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
